// File: rtl/pwm_fader_array.sv
// -----------------------------------------------------------------------------
// pwm_fader_array
//
// Purpose:
//   Multi-channel LED "breathing" controller. One shared period counter feeds
//   CHANNELS comparators. Each channel has its own duty register that sweeps
//   as a triangle between DUTY_MIN and DUTY_MAX. Channels start at staggered
//   duties, so the bank shows a travelling wave.
//
// Optional feature macro: PWM_CENTER_ALIGNED_EN
//   Undefined (default): edge-aligned carrier, cnt runs 0..PERIOD-1 and wraps.
//   Defined: centre-aligned carrier. cnt runs up 0..PERIOD-1 and then down
//   PERIOD-1..0, giving a carrier of 2*PERIOD cycles.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           1 = run; 0 = outputs low and counter parked at 0
//   freeze       1 = hold duties, directions and the update divider
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-cycle pulse in the cycle after each carrier wrap
// -----------------------------------------------------------------------------
module pwm_fader_array #(
   parameter int CLK_FREQ = 25_000_000,
   parameter int PWM_FREQ = 1250,
   parameter int CHANNELS = 8,
   parameter int WIDTH    = 16,
   parameter int MAX_PCT  = 70,
   parameter int MIN_PCT  = 1,
   parameter int STEP     = 1,
   parameter int STEP_DIV = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                freeze,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_tick
);

   localparam int PERIOD   = CLK_FREQ / PWM_FREQ;
   localparam int DUTY_MAX = PERIOD * MAX_PCT / 100;
   localparam int DUTY_MIN = PERIOD * MIN_PCT / 100;
   localparam int SW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [WIDTH-1:0] PERIOD_LAST = WIDTH'(PERIOD - 1);
   localparam logic [WIDTH-1:0] DUTY_MAX_W  = WIDTH'(DUTY_MAX);
   localparam logic [WIDTH-1:0] DUTY_MIN_W  = WIDTH'(DUTY_MIN);
   localparam logic [WIDTH-1:0] STEP_W      = WIDTH'(STEP);
   localparam logic [WIDTH:0]   DUTY_MAX_X  = (WIDTH+1)'(DUTY_MAX);
   localparam logic [WIDTH:0]   DUTY_MIN_X  = (WIDTH+1)'(DUTY_MIN);
   localparam logic [WIDTH:0]   STEP_X      = (WIDTH+1)'(STEP);
   localparam logic [SW-1:0]    STEP_LAST   = SW'(STEP_DIV - 1);

   logic [WIDTH-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]       step_cnt_q, step_cnt_d;
   logic [CHANNELS-1:0] pwm_out_q, pwm_out_d;
   logic                period_tick_q, period_tick_d;
   logic                wrap;
   logic                fade_upd;

   // ---------------------------------------------------------------------
   // Carrier counter
   // ---------------------------------------------------------------------
`ifdef PWM_CENTER_ALIGNED_EN
   logic up_q, up_d;

   always_comb begin
      cnt_d = cnt_q;
      up_d  = up_q;
      wrap  = 1'b0;
      if (!en) begin
         cnt_d = '0;
         up_d  = 1'b1;
      end else if (up_q) begin
         // Top endpoint is held for one extra cycle while turning around.
         if (cnt_q == PERIOD_LAST) begin
            up_d = 1'b0;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end else begin
         // Last cycle of the down phase closes the carrier period.
         if (cnt_q == '0) begin
            up_d = 1'b1;
            wrap = 1'b1;
         end else begin
            cnt_d = cnt_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_q <= 1'b1;
      end else begin
         up_q <= up_d;
      end
   end
`else
   always_comb begin
      cnt_d = cnt_q;
      wrap  = 1'b0;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == PERIOD_LAST) begin
         cnt_d = '0;
         wrap  = 1'b1;
      end else begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Update divider. Freeze stalls it, so the fade resumes exactly where it
   // stopped once freeze is released.
   // ---------------------------------------------------------------------
   always_comb begin
      step_cnt_d    = step_cnt_q;
      period_tick_d = wrap;
      fade_upd      = 1'b0;
      if (wrap && !freeze) begin
         if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            fade_upd   = 1'b1;
         end else begin
            step_cnt_d = step_cnt_q + SW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Per-channel triangle fade and comparator. Duty only moves on a wrap,
   // so each carrier period sees one stable duty value.
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      localparam logic [WIDTH-1:0] DUTY_RST =
         WIDTH'(DUTY_MIN + (gi * (DUTY_MAX - DUTY_MIN)) / CHANNELS);

      logic [WIDTH-1:0] duty_q, duty_d;
      logic             dir_q, dir_d;
      logic [WIDTH:0]   duty_x;

      always_comb begin
         duty_d = duty_q;
         dir_d  = dir_q;
         // One extra bit so duty+STEP and DUTY_MIN+STEP cannot wrap.
         duty_x = {1'b0, duty_q};
         if (fade_upd) begin
            if (dir_q) begin
               if (duty_x + STEP_X >= DUTY_MAX_X) begin
                  duty_d = DUTY_MAX_W;
                  dir_d  = 1'b0;
               end else begin
                  duty_d = duty_q + STEP_W;
               end
            end else begin
               if (duty_x <= DUTY_MIN_X + STEP_X) begin
                  duty_d = DUTY_MIN_W;
                  dir_d  = 1'b1;
               end else begin
                  duty_d = duty_q - STEP_W;
               end
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            duty_q <= DUTY_RST;
            dir_q  <= 1'b1;
         end else begin
            duty_q <= duty_d;
            dir_q  <= dir_d;
         end
      end

      assign pwm_out_d[gi] = en & (cnt_q < duty_q);
   end

   // ---------------------------------------------------------------------
   // Shared state registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         step_cnt_q    <= '0;
         pwm_out_q     <= '0;
         period_tick_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         step_cnt_q    <= step_cnt_d;
         pwm_out_q     <= pwm_out_d;
         period_tick_q <= period_tick_d;
      end
   end

   assign pwm_out     = pwm_out_q;
   assign period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_fader_array.sv
// -----------------------------------------------------------------------------
// tb_pwm_fader_array
//
// Measures the high time of every channel over each carrier period and the
// position of period_tick. The results are compared with a per-channel
// triangle model that the bench advances once per unfrozen period.
// -----------------------------------------------------------------------------
module tb_pwm_fader_array;

   localparam int CLK_FREQ = 10000;
   localparam int PWM_FREQ = 100;
   localparam int CHANNELS = 4;
   localparam int WIDTH    = 16;
   localparam int MAX_PCT  = 70;
   localparam int MIN_PCT  = 1;
   localparam int STEP     = 1;
   localparam int STEP_DIV = 1;

   localparam int PERIOD = CLK_FREQ / PWM_FREQ;
   localparam int DMAX   = PERIOD * MAX_PCT / 100;
   localparam int DMIN   = PERIOD * MIN_PCT / 100;
`ifdef PWM_CENTER_ALIGNED_EN
   localparam int CARRIER = 2 * PERIOD;
   localparam int HMUL    = 2;
`else
   localparam int CARRIER = PERIOD;
   localparam int HMUL    = 1;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                en = 1'b0;
   logic                freeze = 1'b0;
   logic [CHANNELS-1:0] pwm_out;
   logic                period_tick;

   int checks = 0;
   int errors = 0;

   int m_duty [CHANNELS];
   int m_dir  [CHANNELS];
   int exp_init [CHANNELS] = '{1, 18, 35, 52};

   int                  hi [CHANNELS];
   int                  ticks;
   logic                last_tick;
   logic [CHANNELS-1:0] first_vec;

   pwm_fader_array #(
      .CLK_FREQ (CLK_FREQ),
      .PWM_FREQ (PWM_FREQ),
      .CHANNELS (CHANNELS),
      .WIDTH    (WIDTH),
      .MAX_PCT  (MAX_PCT),
      .MIN_PCT  (MIN_PCT),
      .STEP     (STEP),
      .STEP_DIV (STEP_DIV)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .freeze      (freeze),
      .pwm_out     (pwm_out),
      .period_tick (period_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CHANNELS; i++) begin
         m_duty[i] = DMIN + (i * (DMAX - DMIN)) / CHANNELS;
         m_dir[i]  = 1;
      end
   endtask

   // One fade step: climb by STEP until the ceiling, fall until the floor.
   task automatic model_fade();
      for (int i = 0; i < CHANNELS; i++) begin
         if (m_dir[i] == 1) begin
            if (m_duty[i] + STEP >= DMAX) begin
               m_duty[i] = DMAX;
               m_dir[i]  = 0;
            end else begin
               m_duty[i] = m_duty[i] + STEP;
            end
         end else begin
            if (m_duty[i] <= DMIN + STEP) begin
               m_duty[i] = DMIN;
               m_dir[i]  = 1;
            end else begin
               m_duty[i] = m_duty[i] - STEP;
            end
         end
      end
   endtask

   // Samples one full carrier period. It is called at the negedge where cnt
   // is 0, so the first sample reflects cnt=0 and the last one is the tick.
   task automatic measure_window();
      for (int i = 0; i < CHANNELS; i++) hi[i] = 0;
      ticks = 0;
      first_vec = '0;
      last_tick = 1'b0;
      for (int k = 1; k <= CARRIER; k++) begin
         @(negedge clk);
         if (k == 1) first_vec = pwm_out;
         for (int i = 0; i < CHANNELS; i++) hi[i] += int'(pwm_out[i]);
         if (period_tick) ticks++;
         last_tick = period_tick;
      end
   endtask

   task automatic check_window(input string tag);
      for (int i = 0; i < CHANNELS; i++) begin
         check($sformatf("%s high ch%0d", tag, i), hi[i], HMUL * m_duty[i]);
         check($sformatf("%s range ch%0d", tag, i),
               int'(hi[i] >= HMUL * DMIN && hi[i] <= HMUL * DMAX), 1);
      end
      check({tag, " tick count"}, ticks, 1);
      check({tag, " tick at wrap"}, int'(last_tick), 1);
   endtask

   task automatic check_reset_window(input string tag);
      for (int i = 0; i < CHANNELS; i++)
         check($sformatf("%s init ch%0d", tag, i), hi[i], HMUL * exp_init[i]);
      check({tag, " first sample"}, int'(first_vec), 'hF);
      check({tag, " tick count"}, ticks, 1);
      check({tag, " tick at wrap"}, int'(last_tick), 1);
   endtask

   initial begin
      int drop_at;
      int gap;
      int rst_at;
      logic [CHANNELS-1:0] exp_first;

      // Reset state
      rst_n  = 1'b0;
      en     = 1'b1;
      freeze = 1'b0;
      repeat (3) @(negedge clk);
      check("reset pwm_out", int'(pwm_out), 0);
      check("reset period_tick", int'(period_tick), 0);

      // 1. First period after release shows the staggered reset duties
      rst_n = 1'b1;
      model_reset();
      measure_window();
      check_reset_window("s1");
      $display("s1: high %0d %0d %0d %0d", hi[0], hi[1], hi[2], hi[3]);
      model_fade();

      // 2/3. Full sweep: ch0 climbs to the ceiling, falls to the floor, turns
      for (int p = 0; p < 140; p++) begin
         measure_window();
         check_window($sformatf("fade p%0d", p));
         $display("fade p%0d: high %0d %0d %0d %0d", p, hi[0], hi[1], hi[2], hi[3]);
         model_fade();
      end

      // Random freeze pattern, one decision per period
      for (int p = 0; p < 30; p++) begin
         freeze = ($urandom_range(0, 3) == 0);
         measure_window();
         check_window($sformatf("rfrz p%0d", p));
         $display("rfrz p%0d freeze=%0d: high %0d %0d %0d %0d",
                  p, freeze, hi[0], hi[1], hi[2], hi[3]);
         if (!freeze) model_fade();
      end

      // 4. freeze for 5 periods, then resume
      freeze = 1'b1;
      for (int p = 0; p < 5; p++) begin
         measure_window();
         check_window($sformatf("frz p%0d", p));
         $display("frz p%0d: high %0d %0d %0d %0d", p, hi[0], hi[1], hi[2], hi[3]);
      end
      freeze = 1'b0;
      for (int p = 0; p < 3; p++) begin
         measure_window();
         check_window($sformatf("resume p%0d", p));
         $display("resume p%0d: high %0d %0d %0d %0d", p, hi[0], hi[1], hi[2], hi[3]);
         model_fade();
      end

      // 5. en dropped mid-period: once at cnt=40 for 30 cycles, once random
      for (int r = 0; r < 2; r++) begin
         drop_at = (r == 0) ? 40 : int'($urandom_range(5, 90));
         gap     = (r == 0) ? 30 : int'($urandom_range(10, 60));
         repeat (drop_at) @(negedge clk);
         en = 1'b0;
         for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            check($sformatf("en0 r%0d pwm c%0d", r, k), int'(pwm_out), 0);
            check($sformatf("en0 r%0d tick c%0d", r, k), int'(period_tick), 0);
         end
         en = 1'b1;
         measure_window();
         check_window($sformatf("reen r%0d", r));
         exp_first = '0;
         for (int i = 0; i < CHANNELS; i++) exp_first[i] = (m_duty[i] > 0);
         check($sformatf("reen r%0d first sample", r), int'(first_vec), int'(exp_first));
         $display("reen r%0d drop=%0d gap=%0d: high %0d %0d %0d %0d",
                  r, drop_at, gap, hi[0], hi[1], hi[2], hi[3]);
         model_fade();
      end

      // 6. Asynchronous reset part-way through a period
      rst_at = int'($urandom_range(40, 60));
      repeat (rst_at) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("async rst pwm_out", int'(pwm_out), 0);
      check("async rst tick", int'(period_tick), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      measure_window();
      check_reset_window("s6");
      $display("s6 rst_at=%0d: high %0d %0d %0d %0d", rst_at, hi[0], hi[1], hi[2], hi[3]);
      model_fade();
      for (int p = 0; p < 3; p++) begin
         measure_window();
         check_window($sformatf("post rst p%0d", p));
         $display("post rst p%0d: high %0d %0d %0d %0d", p, hi[0], hi[1], hi[2], hi[3]);
         model_fade();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_fader_array.md
Name: pwm_fader_array

Overview:
Multi-channel successor to the single-channel LED fade controller.
- One shared period counter drives CHANNELS independent triangle-fade duty generators.
- Channels start phase-staggered, giving a "breathing wave" across the LED bank.
- Sits between the board clock/reset and the LED pins; it contains its own comparators, so no external PWM core is instantiated.

Parameters:
CLK_FREQ, 25_000_000, input clock frequency in Hz
PWM_FREQ, 1250, PWM carrier frequency in Hz; PERIOD = CLK_FREQ/PWM_FREQ (integer division; must be >= 2 and fit in WIDTH bits)
CHANNELS, 8, number of PWM outputs (1..32)
WIDTH, 16, width of the counter and duty registers
MAX_PCT, 70, fade ceiling: DUTY_MAX = PERIOD*MAX_PCT/100
MIN_PCT, 1, fade floor: DUTY_MIN = PERIOD*MIN_PCT/100 (must be < DUTY_MAX)
STEP, 1, duty increment/decrement per fade update
STEP_DIV, 1, number of PWM periods between fade updates (>= 1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = run; 0 = outputs low, counter parked
freeze  input  1  1 = hold all duties and directions; the carrier keeps running
pwm_out  output  CHANNELS  registered PWM outputs
period_tick  output  1  one-cycle pulse at each period wrap

Behaviour:
- Reset is asynchronous, active-low, and the only reset; all state is clocked on posedge clk.
- Values on reset:
  - cnt = 0, step_cnt = 0, pwm_out = 0, period_tick = 0, dir[i] = 1 (up).
  - duty[i] = DUTY_MIN + (i*(DUTY_MAX-DUTY_MIN))/CHANNELS, computed at elaboration with integer math.
- Counter:
  - When en=1: cnt increments 0..PERIOD-1, then wraps to 0.
  - The wrap cycle is the cycle with cnt==PERIOD-1 and en=1.
- period_tick is registered: it is high for one cycle, in the cycle after the wrap cycle.
- Step counter:
  - On every wrap, step_cnt increments modulo STEP_DIV.
  - A fade update occurs on the wrap where step_cnt==STEP_DIV-1 and freeze=0.
- Fade update, applied per channel in the same cycle:
  - dir=1, duty+STEP >= DUTY_MAX: duty <= DUTY_MAX, dir <= 0.
  - dir=1, otherwise: duty <= duty+STEP.
  - dir=0, duty <= DUTY_MIN+STEP: duty <= DUTY_MIN, dir <= 1.
  - dir=0, otherwise: duty <= duty-STEP.
  - Comparisons use WIDTH+1 bits so that nothing overflows or underflows.
- Duty changes only on a wrap, so every PWM period is glitch-free with no shadow register needed.
- Output: pwm_out[i] <= en & (cnt < duty[i]), registered, so each output lags cnt by 1 cycle.
  - Duty D gives exactly D high cycles per PERIOD.
  - D=0 gives constant low; D >= PERIOD gives constant high.
- freeze=1:
  - Duties and directions hold; step_cnt holds.
  - cnt, pwm_out and period_tick continue normally.
- en=0:
  - The next clock forces cnt <= 0, pwm_out <= 0, period_tick <= 0.
  - step_cnt, duty and dir hold.
  - When en returns to 1, the first period starts at cnt=0 with the held duties.
- en falling mid-period: that period is abandoned, with no fade update and no tick.
- freeze and a wrap in the same cycle: freeze wins, and no update occurs.
- Reset mid-period: everything returns to the reset values immediately (asynchronous); pwm_out goes low without waiting for a clock.

Optional Feature:
PWM_CENTER_ALIGNED_EN
- Defined: the counter runs up 0..PERIOD-1, then down PERIOD-1..0, with each endpoint held for one cycle.
  - Carrier period is 2*PERIOD cycles; the high time is 2*D cycles, centred on cnt=0.
  - The wrap cycle is the last cycle of the down phase (cnt==0, down).
  - period_tick and fade updates fire once per 2*PERIOD cycles.
  - A 1-bit up/down state register is added and resets to up.
- Undefined: edge-aligned operation as described above; no up/down register exists.

Test Plan:
Common bench parameters: CLK_FREQ=10000, PWM_FREQ=100 (PERIOD=100), CHANNELS=4, STEP=1, STEP_DIV=1, MAX_PCT=70, MIN_PCT=1, which gives DUTY_MAX=70, DUTY_MIN=1.
1. Reset release with en=1, freeze=0 -> initial duties 1,18,35,52. In the first period, pwm_out[0..3] are high for 1, 18, 35, 52 cycles. period_tick pulses every 100 cycles.
2. Run 69 periods -> ch0 duty reaches 70 and reverses. The next periods measure 69, 68, ...; ch3 reaches 70 after 18 periods and then descends.
3. Run until ch0 descends to 1 -> the next update gives 2 (dir=1). Duty never measures below 1 or above 70 on any channel.
4. freeze=1 for 5 periods -> high-times are identical in each period and period_tick still pulses 5 times. After release, the fade resumes from the held value.
5. en=0 at cnt=40 for 30 cycles, then en=1 -> pwm_out is 0 from the next cycle and there is no tick. After re-enable, the first high run starts at cnt=0 with unchanged duty.
6. rst_n asserted at cnt=50 -> pwm_out is 0 with no clock. After release, the reset duties from scenario 1 are observed. With PWM_CENTER_ALIGNED_EN defined: ch1 is high for 36 cycles per 200-cycle carrier, and the tick interval is 200.
